// File: rtl/kawari_sync_pkg.sv
// kawari_sync_pkg: chip codes, per-chip horizontal geometry and the vertical
// interval phase encoding shared by the composite sync generator.
package kawari_sync_pkg;

    // Chip select codes
    localparam logic [1:0] CHIP6567R8   = 2'd0;
    localparam logic [1:0] CHIP6567R56A = 2'd1;
    localparam logic [1:0] CHIP6569R1   = 2'd2;
    localparam logic [1:0] CHIP6569R3   = 2'd3;

    // 6567R8 (NTSC, 65 cycles per line)
    localparam int R8_LINE_LEN   = 520;
    localparam int R8_HALF_LEN   = 260;
    // 6567R56A (NTSC, 64 cycles per line)
    localparam int R56A_LINE_LEN = 512;
    localparam int R56A_HALF_LEN = 256;
    // Pulse geometry shared by both 6567 revisions
    localparam int NTSC_HSYNC_W  = 38;
    localparam int NTSC_EQ_W     = 19;
    localparam int NTSC_GAP      = 36;

    // 6569R1 / 6569R3 (PAL, 63 cycles per line)
    localparam int PAL_LINE_LEN  = 504;
    localparam int PAL_HALF_LEN  = 252;
    localparam int PAL_HSYNC_W   = 37;
    localparam int PAL_EQ_W      = 18;
    localparam int PAL_GAP       = 35;

    // Vertical interval phases, in the order they are traversed
    typedef enum logic [1:0] {
        PH_NORMAL  = 2'd0,
        PH_PRE_EQ  = 2'd1,
        PH_SERR    = 2'd2,
        PH_POST_EQ = 2'd3
    } phase_e;

    function automatic logic chip_is_pal(input logic [1:0] chip);
        return (chip == CHIP6569R1) || (chip == CHIP6569R3);
    endfunction

endpackage

// File: rtl/sync_chip_timing.sv
// sync_chip_timing: combinational lookup from chip code to line length,
// half-line length, pulse widths and half-lines per vertical phase.
module sync_chip_timing
    import kawari_sync_pkg::*;
#(
    parameter int X_WIDTH         = 10,
    parameter int NTSC_HALF_LINES = 6,
    parameter int PAL_HALF_LINES  = 5
) (
    input  logic [1:0]         chip_i,
    output logic [X_WIDTH-1:0] line_len_o,
    output logic [X_WIDTH-1:0] half_len_o,
    output logic [X_WIDTH-1:0] hsync_w_o,
    output logic [X_WIDTH-1:0] eq_w_o,
    output logic [X_WIDTH-1:0] gap_o,
    output logic [3:0]         half_lines_o
);

    // Geometry selection; the 6567 revisions differ only in line length
    always_comb begin
        // NOTE: every output gets a value before the case so no path can
        // leave one unassigned and infer a latch.
        line_len_o   = X_WIDTH'(R8_LINE_LEN);
        half_len_o   = X_WIDTH'(R8_HALF_LEN);
        hsync_w_o    = X_WIDTH'(NTSC_HSYNC_W);
        eq_w_o       = X_WIDTH'(NTSC_EQ_W);
        gap_o        = X_WIDTH'(NTSC_GAP);
        half_lines_o = 4'(NTSC_HALF_LINES);
        case (chip_i)
            CHIP6567R8: begin
                line_len_o = X_WIDTH'(R8_LINE_LEN);
                half_len_o = X_WIDTH'(R8_HALF_LEN);
            end
            CHIP6567R56A: begin
                line_len_o = X_WIDTH'(R56A_LINE_LEN);
                half_len_o = X_WIDTH'(R56A_HALF_LEN);
            end
            default: begin
                line_len_o = X_WIDTH'(PAL_LINE_LEN);
                half_len_o = X_WIDTH'(PAL_HALF_LEN);
                hsync_w_o  = X_WIDTH'(PAL_HSYNC_W);
                eq_w_o     = X_WIDTH'(PAL_EQ_W);
                gap_o      = X_WIDTH'(PAL_GAP);
            end
        endcase
        if (chip_is_pal(chip_i)) begin
            half_lines_o = 4'(PAL_HALF_LINES);
        end
    end

endmodule

// File: rtl/composite_sync_gen.sv
// composite_sync_gen: composite sync for normal lines and the vertical
// interval (pre-equalization, serration, post-equalization), counted in
// half-lines from a vertical trigger. Runs on the dot4x clock.
// Optional feature macro: INTERLACE_EN -- when defined, a trigger with
// field=1 starts the interval on a mid-line boundary instead of a line start.
module composite_sync_gen
    import kawari_sync_pkg::*;
#(
    parameter int X_WIDTH         = 10,
    parameter int NTSC_HALF_LINES = 6,
    parameter int PAL_HALF_LINES  = 5,
    parameter int HS_START        = 10
) (
    input  logic               clk_dot4x,
    input  logic               rst_n,
    input  logic [1:0]         chip,
    input  logic [X_WIDTH-1:0] raster_x,
    input  logic               vtrig,
    input  logic               field,
    output logic               sync,
    output logic               vsync,
    output logic [1:0]         phase,
    output logic [3:0]         half_cnt
);

    // Registered state
    logic [1:0]         chip_q, chip_d;
    logic [X_WIDTH-1:0] x_prev_q;
    phase_e             phase_q, phase_d;
    logic [3:0]         half_cnt_q, half_cnt_d;
    logic               pending_q, pending_d;
    logic               sync_q, sync_d;

    // Geometry of the chip currently in force
    logic [X_WIDTH-1:0] line_len, half_len, hsync_w, eq_w, gap;
    logic [3:0]         half_lines;

    sync_chip_timing #(
        .X_WIDTH        (X_WIDTH),
        .NTSC_HALF_LINES(NTSC_HALF_LINES),
        .PAL_HALF_LINES (PAL_HALF_LINES)
    ) u_timing (
        .chip_i      (chip_q),
        .line_len_o  (line_len),
        .half_len_o  (half_len),
        .hsync_w_o   (hsync_w),
        .eq_w_o      (eq_w),
        .gap_o       (gap),
        .half_lines_o(half_lines)
    );

    // Position relative to the line-start sync edge, and within the half-line
    logic [X_WIDTH-1:0] rel, hp;
    always_comb begin
        if (raster_x >= X_WIDTH'(HS_START)) begin
            rel = raster_x - X_WIDTH'(HS_START);
        end else begin
            rel = raster_x + line_len - X_WIDTH'(HS_START);
        end
        hp = (rel < half_len) ? rel : (rel - half_len);
    end

    // Boundaries fire only on the first dot4x cycle of a new x value
    logic x_changed, full_ev, mid_ev, boundary, start_ev;
    assign x_changed = (raster_x != x_prev_q);
    assign full_ev   = x_changed && (rel == '0);
    assign mid_ev    = x_changed && (rel == half_len);
    assign boundary  = full_ev || mid_ev;

`ifdef INTERLACE_EN
    // Field of the armed trigger picks the starting boundary type
    logic pend_odd_q, pend_odd_d;
    logic start_odd;
    assign start_odd = vtrig ? field : pend_odd_q;
    assign start_ev  = (pending_q || vtrig) && (start_odd ? mid_ev : full_ev);
`else
    logic unused_field;
    assign unused_field = field;
    assign start_ev     = (pending_q || vtrig) && full_ev;
`endif

    // The chip is only sampled in NORMAL so a sequence keeps one geometry
    assign chip_d = (phase_q == PH_NORMAL) ? chip : chip_q;

    // Phase sequencing, half-line countdown and trigger arming
    always_comb begin
        phase_d    = phase_q;
        half_cnt_d = half_cnt_q;
        pending_d  = pending_q;
`ifdef INTERLACE_EN
        pend_odd_d = pend_odd_q;
`endif
        case (phase_q)
            PH_NORMAL: begin
                if (start_ev) begin
                    phase_d    = PH_PRE_EQ;
                    half_cnt_d = half_lines;
                    pending_d  = 1'b0;
                end else if (vtrig) begin
                    pending_d  = 1'b1;
`ifdef INTERLACE_EN
                    pend_odd_d = field;
`endif
                end
            end
            default: begin
                if (boundary) begin
                    if (half_cnt_q == 4'd1) begin
                        case (phase_q)
                            PH_PRE_EQ: begin
                                phase_d    = PH_SERR;
                                half_cnt_d = half_lines;
                            end
                            PH_SERR: begin
                                phase_d    = PH_POST_EQ;
                                half_cnt_d = half_lines;
                            end
                            default: begin
                                phase_d    = PH_NORMAL;
                                half_cnt_d = 4'd0;
                            end
                        endcase
                    end else begin
                        half_cnt_d = half_cnt_q - 4'd1;
                    end
                end
            end
        endcase
    end

    // Sync level is shaped by the phase being entered, so a new phase's
    // first pulse already has that phase's width
    always_comb begin
        case (phase_d)
            PH_NORMAL: sync_d = (rel < hsync_w);
            PH_SERR:   sync_d = (hp < (half_len - gap));
            default:   sync_d = (hp < eq_w);
        endcase
    end

    // State registers
    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            chip_q     <= CHIP6567R8;
            x_prev_q   <= '0;
            phase_q    <= PH_NORMAL;
            half_cnt_q <= 4'd0;
            pending_q  <= 1'b0;
            sync_q     <= 1'b0;
`ifdef INTERLACE_EN
            pend_odd_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments let every register sample the
            // pre-edge values regardless of statement order.
            chip_q     <= chip_d;
            x_prev_q   <= raster_x;
            phase_q    <= phase_d;
            half_cnt_q <= half_cnt_d;
            pending_q  <= pending_d;
            sync_q     <= sync_d;
`ifdef INTERLACE_EN
            pend_odd_q <= pend_odd_d;
`endif
        end
    end

    assign sync     = sync_q;
    assign vsync    = (phase_q == PH_SERR);
    assign phase    = phase_q;
    assign half_cnt = half_cnt_q;

endmodule

// File: tb/tb_composite_sync_gen.sv
// tb_composite_sync_gen: sweeps raster_x with random dot hold times and
// random triggers; a half-line-counting reference model is compared with
// the DUT on every cycle, plus literal pin checks for the directed cases.
module tb_composite_sync_gen;
    import kawari_sync_pkg::*;

    localparam int XW = 10;
    localparam int HS = 10;

    logic          clk_dot4x = 1'b0;
    logic          rst_n     = 1'b0;
    logic [1:0]    chip      = CHIP6567R8;
    logic [XW-1:0] raster_x  = '0;
    logic          vtrig     = 1'b0;
    logic          field     = 1'b0;
    logic          sync, vsync;
    logic [1:0]    phase;
    logic [3:0]    half_cnt;

    composite_sync_gen #(
        .X_WIDTH(XW), .NTSC_HALF_LINES(6), .PAL_HALF_LINES(5), .HS_START(HS)
    ) dut (
        .clk_dot4x(clk_dot4x), .rst_n(rst_n), .chip(chip), .raster_x(raster_x),
        .vtrig(vtrig), .field(field), .sync(sync), .vsync(vsync),
        .phase(phase), .half_cnt(half_cnt)
    );

    always #5 clk_dot4x = ~clk_dot4x;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (x=%0d t=%0t)",
                      name, act, exp, raster_x, $time);
    endtask

    // Reference geometry, written out as plain numbers
    function automatic bit ref_pal(input logic [1:0] c);
        return (c == CHIP6569R1) || (c == CHIP6569R3);
    endfunction
    function automatic int ref_len(input logic [1:0] c);
        if (ref_pal(c)) return 504;
        return (c == CHIP6567R56A) ? 512 : 520;
    endfunction
    function automatic int ref_hsw(input logic [1:0] c); return ref_pal(c) ? 37 : 38; endfunction
    function automatic int ref_eq (input logic [1:0] c); return ref_pal(c) ? 18 : 19; endfunction
    function automatic int ref_gap(input logic [1:0] c); return ref_pal(c) ? 35 : 36; endfunction
    function automatic int ref_n  (input logic [1:0] c); return ref_pal(c) ? 5 : 6; endfunction

    // Model: m_seq = half-lines elapsed since the triggering boundary, -1 idle
    int         m_seq = -1, m_n = 0, m_prev = 0;
    logic [1:0] m_chip = CHIP6567R8, mc;
    bit         m_pend = 0, m_pend_odd = 0;
    bit         e_sync = 0;
    int         e_phase = 0, e_half = 0;
    int         mL, mH, mrel, mhp;
    bit         mfull, mmid, midle, modd;

    initial forever begin
        @(posedge clk_dot4x or negedge rst_n);
        if (!rst_n) begin
            m_seq = -1; m_n = 0; m_prev = 0; m_chip = CHIP6567R8;
            m_pend = 0; m_pend_odd = 0; e_sync = 0; e_phase = 0; e_half = 0;
        end else begin
            mc    = m_chip;
            mL    = ref_len(mc);
            mH    = mL / 2;
            mrel  = (int'(raster_x) >= HS) ? int'(raster_x) - HS : int'(raster_x) + mL - HS;
            mhp   = (mrel < mH) ? mrel : mrel - mH;
            mfull = (int'(raster_x) != m_prev) && (mrel == 0);
            mmid  = (int'(raster_x) != m_prev) && (mrel == mH);
            midle = (m_seq < 0);
            if (midle) begin
                modd = vtrig ? field : m_pend_odd;
`ifndef INTERLACE_EN
                modd = 0;
`endif
                if ((m_pend || vtrig) && (modd ? mmid : mfull)) begin
                    m_seq = 0; m_n = ref_n(mc); m_pend = 0;
                end else if (vtrig) begin
                    m_pend = 1; m_pend_odd = field;
                end
            end else if (mfull || mmid) begin
                m_seq++;
                if (m_seq == 3 * m_n) m_seq = -1;
            end
            if (midle) m_chip = chip;
            m_prev = int'(raster_x);
            if (m_seq < 0) begin
                e_phase = 0; e_half = 0; e_sync = (mrel < ref_hsw(mc));
            end else begin
                e_phase = 1 + m_seq / m_n;
                e_half  = m_n - (m_seq % m_n);
                e_sync  = (e_phase == 2) ? (mhp < mH - ref_gap(mc)) : (mhp < ref_eq(mc));
            end
        end
    end

    // Every-cycle comparison, away from the active edge
    initial forever begin
        @(negedge clk_dot4x);
        check("sync",     int'(sync),     int'(e_sync));
        check("phase",    int'(phase),    e_phase);
        check("half_cnt", int'(half_cnt), e_half);
        check("vsync",    int'(vsync),    int'(e_phase == 2));
    end

    // Raster stimulus: each x is held for 1..2 dot4x cycles
    int line_len  = 520;
    int hold_left = 0;

    task automatic step_dot(input bit trig);
        repeat (hold_left) @(negedge clk_dot4x);
        raster_x = (int'(raster_x) + 1 == line_len) ? '0 : raster_x + 1'b1;
        vtrig    = trig;
        @(negedge clk_dot4x);
        vtrig     = 1'b0;
        hold_left = $urandom_range(1, 2) - 1;
    endtask

    // Advance to the next occurrence of x=tgt, optionally triggering there
    task automatic goto_x(input int tgt, input bit trig = 1'b0);
        for (int i = 0; i < 1100; i++) begin
            int nxt;
            nxt = (int'(raster_x) + 1 == line_len) ? 0 : int'(raster_x) + 1;
            step_dot(trig && (nxt == tgt));
            if (int'(raster_x) == tgt) return;
        end
        check("goto_timeout", int'(raster_x), tgt);
    endtask

    task automatic set_chip(input logic [1:0] c);
        chip     = c;
        line_len = ref_len(c);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk_dot4x);
        // Reset held while x sweeps, then release and sweep R8
        goto_x(100);
        check("rst_sync", int'(sync), 0);
        check("rst_phase", int'(phase), 0);
        @(posedge clk_dot4x); #1 rst_n = 1'b1;
        @(negedge clk_dot4x);
        goto_x(9);   check("hs_x9", int'(sync), 0);
        goto_x(10);  check("hs_x10", int'(sync), 1);
        goto_x(47);  check("hs_x47", int'(sync), 1);
        goto_x(48);  check("hs_x48", int'(sync), 0);

        // R8 vertical interval
        goto_x(300, 1'b1);
        goto_x(10);  check("r8_pre_phase", int'(phase), 1);
                     check("r8_pre_cnt", int'(half_cnt), 6);
        goto_x(28);  check("r8_eq_x28", int'(sync), 1);
        goto_x(29);  check("r8_eq_x29", int'(sync), 0);
        goto_x(270); check("r8_eq_mid", int'(sync), 1);
                     check("r8_pre_cnt5", int'(half_cnt), 5);
        repeat (3) goto_x(10);
        check("r8_serr_phase", int'(phase), 2);
        check("r8_serr_vsync", int'(vsync), 1);
        goto_x(233); check("r8_serr_x233", int'(sync), 1);
        goto_x(234); check("r8_serr_x234", int'(sync), 0);
        goto_x(493); check("r8_serr_x493", int'(sync), 1);
        goto_x(494); check("r8_serr_x494", int'(sync), 0);
        repeat (3) goto_x(10);
        check("r8_post_phase", int'(phase), 3);
        repeat (3) goto_x(10);
        check("r8_end_phase", int'(phase), 0);
        check("r8_end_cnt", int'(half_cnt), 0);
        goto_x(270); check("r8_no_mid", int'(sync), 0);

        // 6569 PAL interval
        goto_x(0); set_chip(CHIP6569R3);
        goto_x(300, 1'b1);
        goto_x(10);  check("pal_pre_cnt", int'(half_cnt), 5);
        goto_x(27);  check("pal_eq_x27", int'(sync), 1);
        goto_x(28);  check("pal_eq_x28", int'(sync), 0);
        repeat (3) goto_x(262);
        check("pal_serr_phase", int'(phase), 2);
        goto_x(478); check("pal_serr_x478", int'(sync), 1);
        goto_x(479); check("pal_serr_x479", int'(sync), 0);
        goto_x(226); check("pal_serr_x226", int'(sync), 1);
        goto_x(227); check("pal_serr_x227", int'(sync), 0);
        repeat (2) goto_x(10);
        check("pal_post_phase", int'(phase), 3);
        repeat (3) goto_x(262);
        check("pal_end_phase", int'(phase), 0);
        goto_x(10);  check("pal_hs", int'(sync), 1);

        // Collisions: trigger on the boundary cycle, retrigger during SERR
        goto_x(0); set_chip(CHIP6567R8);
        goto_x(10, 1'b1);
        check("col_phase", int'(phase), 1);
        check("col_cnt", int'(half_cnt), 6);
        repeat (3) goto_x(10);
        goto_x(100, 1'b1); check("col_retrig", int'(phase), 2);
        repeat (6) goto_x(10);
        check("col_end", int'(phase), 0);
        goto_x(10);  check("col_no_pend", int'(phase), 0);

        // Chip change during SERR
        goto_x(300, 1'b1);
        repeat (4) goto_x(10);
        goto_x(0); set_chip(CHIP6567R56A);
        goto_x(233); check("cc_serr_x233", int'(sync), 1);
        goto_x(234); check("cc_serr_x234", int'(sync), 0);
        repeat (5) goto_x(10);
        check("cc_end", int'(phase), 0);
        goto_x(47);  check("cc_hs_x47", int'(sync), 1);
        goto_x(48);  check("cc_hs_x48", int'(sync), 0);
        goto_x(300, 1'b1);
        goto_x(10);  check("cc_pre", int'(phase), 1);
        goto_x(266); check("cc_mid_x266", int'(sync), 1);
        check("cc_mid_cnt", int'(half_cnt), 5);
        repeat (9) goto_x(10);
        check("cc_end2", int'(phase), 0);

        // Reset in the middle of a sequence
        goto_x(300, 1'b1);
        goto_x(10);
        @(posedge clk_dot4x); #1 rst_n = 1'b0;
        @(negedge clk_dot4x);
        check("mid_rst_phase", int'(phase), 0);
        check("mid_rst_sync", int'(sync), 0);
        @(posedge clk_dot4x); #1 rst_n = 1'b1;
        @(negedge clk_dot4x);
        goto_x(10);  check("post_rst_phase", int'(phase), 0);

`ifdef INTERLACE_EN
        // Odd field starts on the mid boundary and ends on one
        goto_x(0); set_chip(CHIP6567R8);
        field = 1'b1;
        goto_x(100, 1'b1);
        field = 1'b0;
        goto_x(270); check("il_pre", int'(phase), 1);
        repeat (9) goto_x(270);
        check("il_end", int'(phase), 0);
        check("il_no_mid", int'(sync), 0);
        goto_x(10);  check("il_hs", int'(sync), 1);
`endif

        // Random lines: random chip at line start, sparse random triggers
        for (int l = 0; l < 15; l++) begin
            goto_x(0);
            if ($urandom_range(0, 2) == 0) set_chip(2'($urandom_range(0, 3)));
            field = 1'($urandom);
            for (int d = 1; d < line_len; d++) step_dot($urandom_range(0, 499) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
